// File: rtl/bus_parity_peer_pkg.sv
// Shared definitions for the parity-bus peer: state codes, parity helper, default sizes.
package bus_parity_peer_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_TMO   = 15;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RACK = 3'd1,
    S_RREL = 3'd2,
    S_TSET = 3'd3,
    S_THLD = 3'd4,
    S_TREL = 3'd5
  } state_e;

  // Odd-parity flag: 1 when the word holds an odd number of ones (callers zero-extend).
  function automatic logic odd_par(input logic [31:0] v);
    return ^v;
  endfunction
endpackage

// File: rtl/bus_peer_fifo.sv
// Synchronous RX FIFO; a pop in the same cycle frees a full slot for a simultaneous push.
module bus_peer_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             cp,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge cp) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge cp) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/bus_parity_peer.sv
// Far-end station on the inverted wired-AND parity bus: strobed receive into a FIFO, granted transmit with ack/timeout.
// Define PARITY_CHECK_EN to drop received words with bad parity; otherwise every word is accepted.
module bus_parity_peer
  import bus_parity_peer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int TMO   = DEF_TMO
) (
  input  logic             cp,
  input  logic             rst,
  input  logic [WIDTH-1:0] bus_in_,
  input  logic             par_in_,
  input  logic             stb_in_,
  input  logic             ack_in_,
  output logic [WIDTH-1:0] bus_out_,
  output logic             par_out_,
  output logic             bus_oe,
  output logic             stb_out_,
  output logic             ack_out_,
  input  logic             gnt,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_rd,
  output logic             perr,
  output logic             ovf,
  output logic             tmo
);
  localparam int TW = $clog2(TMO + 1);

  state_e           state, nxt;
  logic [WIDTH-1:0] d, tx_reg;
  logic [TW-1:0]    tmr;
  logic             tx_full, par_ok, fifo_full, fifo_empty;
  logic             rx_req, can_push, push, bad_par, drop;
  logic             tx_start, ack_seen, timeout, tx_done;

  assign d = ~bus_in_;

`ifdef PARITY_CHECK_EN
  logic p;
  assign p      = ~par_in_;
  assign par_ok = (odd_par(32'(d)) == p);
`else
  logic unused_par;
  assign unused_par = par_in_;
  assign par_ok     = 1'b1;
`endif

  // Receive has priority: a transmit only starts in an IDLE cycle with no strobe.
  assign rx_req   = (state == S_IDLE) && !stb_in_;
  assign can_push = !fifo_full || (rx_rd && !fifo_empty);
  assign push     = rx_req && par_ok && can_push;
  assign bad_par  = rx_req && !par_ok;
  assign drop     = rx_req && par_ok && !can_push;
  assign tx_start = (state == S_IDLE) && stb_in_ && tx_full && gnt;
  assign ack_seen = (state == S_THLD) && !ack_in_;
  assign timeout  = (state == S_THLD) && ack_in_ && (tmr == TW'(TMO - 1));
  assign tx_done  = ack_seen || timeout;

  bus_peer_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .cp    (cp),
    .rst   (rst),
    .push  (push),
    .din   (d),
    .pop   (rx_rd),
    .head  (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge cp) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (rx_req)        nxt = push ? S_RACK : S_RREL;
              else if (tx_start) nxt = S_TSET;
      S_RACK: nxt = S_RREL;
      S_RREL: if (stb_in_) nxt = S_IDLE;
      S_TSET: nxt = S_THLD;
      S_THLD: if (tx_done) nxt = S_TREL;
      S_TREL: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus_oe   = (state == S_TSET) || (state == S_THLD);
    bus_out_ = '1;
    par_out_ = 1'b1;
    if (bus_oe) begin
      bus_out_ = ~tx_reg;
      par_out_ = ~odd_par(32'(tx_reg));
    end
    stb_out_ = (state != S_THLD);
    ack_out_ = (state != S_RACK);
  end

  // TX holding register and the THLD ack timer.
  always_ff @(posedge cp) begin
    if (rst) begin
      tx_full <= 1'b0;
      tx_reg  <= '0;
      tmr     <= '0;
    end else begin
      if (tx_done) begin
        tx_full <= 1'b0;
      end else if (tx_valid && !tx_full) begin
        tx_full <= 1'b1;
        tx_reg  <= tx_data;
      end
      if (state == S_TSET)      tmr <= '0;
      else if (state == S_THLD) tmr <= tmr + 1'b1;
    end
  end

  always_ff @(posedge cp) begin
    if (rst) begin
      perr <= 1'b0;
      tmo  <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      perr <= bad_par;
      tmo  <= timeout;
      if (drop) ovf <= 1'b1;
    end
  end

  assign tx_ready = !tx_full;
  assign rx_valid = !fifo_empty;
endmodule

// File: tb/tb_bus_parity_peer.sv
// Directed bench for bus_parity_peer: scoreboard queues for RX pops and TX strobes plus inline flag checks.
module tb_bus_parity_peer;
  logic       cp = 1'b0;
  logic       rst;
  logic [3:0] bus_in_, bus_out_, tx_data, rx_data;
  logic       par_in_, stb_in_, ack_in_, par_out_, bus_oe, stb_out_, ack_out_;
  logic       gnt, tx_valid, tx_ready, rx_valid, rx_rd, perr, ovf, tmo;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] rx_q[$];
  logic [5:0] tx_q[$];   // {bus_oe, bus_out_, par_out_} expected at strobe
  logic       prev_stb = 1'b1;

  bus_parity_peer dut (
    .cp(cp), .rst(rst), .bus_in_(bus_in_), .par_in_(par_in_), .stb_in_(stb_in_),
    .ack_in_(ack_in_), .bus_out_(bus_out_), .par_out_(par_out_), .bus_oe(bus_oe),
    .stb_out_(stb_out_), .ack_out_(ack_out_), .gnt(gnt), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_rd(rx_rd), .perr(perr), .ovf(ovf), .tmo(tmo)
  );

  always #5 cp = ~cp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge cp);
    #1;
  endtask

  // Monitor: checks FIFO head on every pop and the driven word on every falling strobe.
  always @(negedge cp) begin
    logic [3:0] er;
    logic [5:0] et;
    if (!rst && rx_rd && rx_valid) begin
      if (rx_q.size() == 0) chk("rx_unexpected_pop", 32'(rx_data), 32'hFFFF);
      else begin
        er = rx_q.pop_front();
        chk("rx_data", 32'(rx_data), 32'(er));
      end
    end
    if (prev_stb && !stb_out_) begin
      if (tx_q.size() == 0) chk("tx_unexpected_stb", 32'({bus_oe, bus_out_, par_out_}), 32'hFFFF);
      else begin
        et = tx_q.pop_front();
        chk("tx_word", 32'({bus_oe, bus_out_, par_out_}), 32'(et));
      end
    end
    prev_stb = stb_out_;
  end

  function automatic logic [12:0] outs();
    return {bus_out_, par_out_, stb_out_, ack_out_, bus_oe, tx_ready, rx_valid, perr, ovf, tmo};
  endfunction

  localparam logic [12:0] RST_OUTS = {4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic pop_one();
    rx_rd = 1'b1; step(); rx_rd = 1'b0;
  endtask

  // Good-word strobe: IDLE -> RACK -> RREL -> IDLE.
  task automatic strobe_good(input logic [3:0] b, input logic p, input logic [3:0] dexp);
    bus_in_ = b; par_in_ = p; stb_in_ = 1'b0;
    rx_q.push_back(dexp);
    step(); stb_in_ = 1'b1; step(2);
  endtask

  logic [3:0] fill_bus [4] = '{4'b1110, 4'b1001, 4'b1000, 4'b0000};
  logic       fill_par [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [3:0] fill_d   [4] = '{4'b0001, 4'b0110, 4'b0111, 4'b1111};

  initial begin
    int cnt;
    rst = 1'b1; bus_in_ = 4'hF; par_in_ = 1'b1; stb_in_ = 1'b1; ack_in_ = 1'b1;
    gnt = 1'b0; tx_data = 4'h0; tx_valid = 1'b0; rx_rd = 1'b0;
    step(2);
    chk("reset_outs", 32'(outs()), 32'(RST_OUTS));
    rst = 1'b0;
    step();

    // 1: good word, strobe held 3 cycles
    bus_in_ = 4'b1100; par_in_ = 1'b1; stb_in_ = 1'b0;
    rx_q.push_back(4'b0011);
    step();
    chk("t1_ack_low", 32'(ack_out_), 0);
    chk("t1_rx_valid", 32'(rx_valid), 1);
    step();
    chk("t1_ack_one_cycle", 32'(ack_out_), 1);
    step();
    stb_in_ = 1'b1; step();
    pop_one();
    chk("t1_no_double_capture", 32'(rx_valid), 0);

    // 2: parity error
    bus_in_ = 4'b0111; par_in_ = 1'b1; stb_in_ = 1'b0;
`ifdef PARITY_CHECK_EN
    step();
    chk("t2_perr", 32'(perr), 1);
    chk("t2_no_ack", 32'(ack_out_), 1);
    chk("t2_fifo_unchanged", 32'(rx_valid), 0);
    stb_in_ = 1'b1; step();
    chk("t2_perr_pulse", 32'(perr), 0);
    step();
`else
    rx_q.push_back(4'b1000);
    step();
    chk("t2_perr_tied", 32'(perr), 0);
    chk("t2_ack", 32'(ack_out_), 0);
    stb_in_ = 1'b1; step(2);
    pop_one();
`endif

    // 3: overflow and same-cycle pop+push while full
    for (int i = 0; i < 4; i++) strobe_good(fill_bus[i], fill_par[i], fill_d[i]);
    chk("t3_no_ovf_yet", 32'(ovf), 0);
    bus_in_ = 4'b1010; par_in_ = 1'b1; stb_in_ = 1'b0;
    step();
    chk("t3_ovf", 32'(ovf), 1);
    chk("t3_drop_no_ack", 32'(ack_out_), 1);
    stb_in_ = 1'b1; step();
    bus_in_ = 4'b1101; par_in_ = 1'b0; stb_in_ = 1'b0; rx_rd = 1'b1;
    rx_q.push_back(4'b0010);
    step();
    rx_rd = 1'b0; stb_in_ = 1'b1;
    chk("t3_full_pop_push_ack", 32'(ack_out_), 0);
    step(2);
    rx_rd = 1'b1; step(4); rx_rd = 1'b0;
    chk("t3_drained", 32'(rx_valid), 0);
    chk("t3_ovf_sticky", 32'(ovf), 1);

    // 4: transmit with ack
    tx_data = 4'b1010; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    chk("t4_tx_ready_busy", 32'(tx_ready), 0);
    tx_q.push_back({1'b1, 4'b0101, 1'b1});
    gnt = 1'b1; step();
    chk("t4_tset", 32'({bus_oe, bus_out_, par_out_, stb_out_}), 32'({1'b1, 4'b0101, 1'b1, 1'b1}));
    step();
    chk("t4_thld_stb", 32'(stb_out_), 0);
    ack_in_ = 1'b0; step(); ack_in_ = 1'b1;
    chk("t4_trel", 32'({bus_oe, bus_out_, par_out_, stb_out_, tx_ready, tmo}),
        32'({1'b0, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0}));
    gnt = 1'b0; step();

    // 5: transmit timeout
    tx_data = 4'b1110; tx_valid = 1'b1; step(); tx_valid = 1'b0;
    tx_q.push_back({1'b1, 4'b0001, 1'b0});
    gnt = 1'b1; step();
    chk("t5_par_out", 32'(par_out_), 0);
    step();
    cnt = 0;
    while (!tmo && cnt < 40) begin step(); cnt++; end
    chk("t5_tmo_cycles", 32'(cnt), 15);
    chk("t5_released", 32'({bus_oe, stb_out_, tx_ready}), 32'({1'b0, 1'b1, 1'b1}));
    gnt = 1'b0; step();
    chk("t5_tmo_pulse", 32'(tmo), 0);

    // 6: receive wins over pending transmit, then reset during THLD
    tx_data = 4'b0011; tx_valid = 1'b1; step(); tx_valid = 1'b0;
    gnt = 1'b1; bus_in_ = 4'b0110; par_in_ = 1'b1; stb_in_ = 1'b0;
    rx_q.push_back(4'b1001);
    step();
    chk("t6_rx_first", 32'({bus_oe, ack_out_}), 32'({1'b0, 1'b0}));
    stb_in_ = 1'b1; rx_rd = 1'b1; step(); rx_rd = 1'b0;
    step();
    chk("t6_idle_no_oe", 32'(bus_oe), 0);
    tx_q.push_back({1'b1, 4'b1100, 1'b1});
    step();
    chk("t6_tx_after_rx", 32'(bus_oe), 1);
    step(3);
    chk("t6_in_thld", 32'(stb_out_), 0);
    rst = 1'b1; step(); rst = 1'b0; gnt = 1'b0;
    chk("t6_rst_mid_tx", 32'(outs()), 32'(RST_OUTS));
    step(2);
    chk("rx_queue_empty", 32'(rx_q.size()), 0);
    chk("tx_queue_empty", 32'(tx_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
